// File: rtl/uart_receiver.sv
// UART receiver: oversampled start detection, majority-vote bit sampling,
// 5-8 data bits LSB first, optional parity, 1/2 stop bits, one-cycle DONE handoff to the RX FIFO.
module uart_receiver #(
   parameter int OVERSAMPLE  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       rx_i,
   input  logic       ov_baud_rt_i,
   input  logic       rx_enable_i,
   input  logic [1:0] data_width_i,
   input  logic       parity_en_i,
   input  logic       parity_odd_i,
   input  logic       stop_bits_i,
   input  logic       rx_fifo_full_i,
   output logic [7:0] data_rx_o,
   output logic       rx_fifo_write_o,
   output logic       rx_done_o,
   output logic       frame_error_o,
   output logic       parity_error_o,
   output logic       overrun_error_o,
   output logic       busy_o
);
   localparam int TW = $clog2(OVERSAMPLE);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE} state_t;

   state_t            state, state_nx;
   logic [SYNC_STAGES-1:0] sync;
   logic              rxs;
   logic [TW-1:0]     tick_cnt;
   logic [1:0]        votes;
   logic [2:0]        bit_cnt;
   logic [7:0]        shreg;
   logic [1:0]        cfg_dw;
   logic              cfg_pen, cfg_odd, cfg_stop2;
   logic              ferr, perr, armed;
   logic              entry, period_end, sample_pt, bit_val, par_exp;

   assign rxs        = sync[SYNC_STAGES-1];
   assign entry      = (state_nx != state);
   assign period_end = ov_baud_rt_i && (tick_cnt == TW'(OVERSAMPLE-1));
   assign sample_pt  = ov_baud_rt_i && (tick_cnt >= TW'(OVERSAMPLE/2-1))
                                    && (tick_cnt <= TW'(OVERSAMPLE/2+1));
   // All three votes land well before the period end, so the tally is complete there.
   assign bit_val    = votes[1];
   assign par_exp    = cfg_odd ? ~^shreg : ^shreg;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) sync <= '1;
      else       sync <= {sync[SYNC_STAGES-2:0], rx_i};
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= S_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:   if (!rxs && rx_enable_i && armed) state_nx = S_START;
         S_START:  if (period_end) state_nx = bit_val ? S_IDLE : S_DATA;
         S_DATA:   if (period_end && bit_cnt == ({1'b0, cfg_dw} + 3'd4))
                      state_nx = cfg_pen ? S_PARITY : S_STOP;
         S_PARITY: if (period_end) state_nx = S_STOP;
         S_STOP:   if (period_end && bit_cnt == {2'b00, cfg_stop2}) state_nx = S_DONE;
         S_DONE:   state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      busy_o          = (state != S_IDLE);
      rx_done_o       = (state == S_DONE);
      rx_fifo_write_o = (state == S_DONE) && !rx_fifo_full_i;
      overrun_error_o = (state == S_DONE) &&  rx_fifo_full_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tick_cnt <= '0;
         votes    <= '0;
      end else begin
         if (entry)             tick_cnt <= '0;
         else if (period_end)   tick_cnt <= '0;
         else if (ov_baud_rt_i) tick_cnt <= tick_cnt + 1'b1;

         if (entry || period_end)  votes <= '0;
         else if (sample_pt && rxs) votes <= votes + 2'd1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         bit_cnt   <= '0;
         shreg     <= '0;
         cfg_dw    <= '0;
         cfg_pen   <= 1'b0;
         cfg_odd   <= 1'b0;
         cfg_stop2 <= 1'b0;
         ferr      <= 1'b0;
         perr      <= 1'b0;
      end else begin
         if (state == S_IDLE && state_nx == S_START) begin
            cfg_dw    <= data_width_i;
            cfg_pen   <= parity_en_i;
            cfg_odd   <= parity_odd_i;
            cfg_stop2 <= stop_bits_i;
            shreg     <= '0;
            ferr      <= 1'b0;
            perr      <= 1'b0;
         end
         if (entry) bit_cnt <= '0;
         else if (period_end && (state == S_DATA || state == S_STOP)) bit_cnt <= bit_cnt + 3'd1;

         if (state == S_DATA && period_end)   shreg <= {bit_val, shreg[7:1]};
         if (state == S_PARITY && period_end && bit_val != par_exp) perr <= 1'b1;
         if (state == S_STOP && period_end && !bit_val) ferr <= 1'b1;
      end
   end

   // Result registers load on the edge into DONE so they are valid during rx_done_o.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         data_rx_o      <= '0;
         frame_error_o  <= 1'b0;
         parity_error_o <= 1'b0;
      end else if (state == S_STOP && state_nx == S_DONE) begin
         data_rx_o      <= shreg >> (2'd3 - cfg_dw);
         frame_error_o  <= ferr | ~bit_val;
         parity_error_o <= perr;
      end
   end

   // After a framing error (e.g. break) the line must return high before a new start counts.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)                                 armed <= 1'b1;
      else if (state == S_DONE && frame_error_o) armed <= rxs;
      else if (rxs)                              armed <= 1'b1;
   end
endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed scenarios plus randomized frames
// compared against a frame-level reference model.
module tb_uart_receiver;
   logic       clk = 1'b0, rst = 1'b1, rx = 1'b1, tick = 1'b0, en = 1'b1;
   logic [1:0] dw = 2'd3;
   logic       pen = 1'b0, podd = 1'b0, s2 = 1'b0, full = 1'b0;
   logic [7:0] data_rx_o;
   logic       rx_fifo_write_o, rx_done_o, frame_error_o, parity_error_o, overrun_error_o, busy_o;

   int total = 0, bad = 0, stray = 0;
   int div = 4, tcnt = 0;

   typedef struct {logic [7:0] d; logic fe, pe, wr, ov;} rec_t;
   rec_t q[$];

   uart_receiver #(.OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
      .clk_i(clk), .rst_i(rst), .rx_i(rx), .ov_baud_rt_i(tick), .rx_enable_i(en),
      .data_width_i(dw), .parity_en_i(pen), .parity_odd_i(podd), .stop_bits_i(s2),
      .rx_fifo_full_i(full), .data_rx_o(data_rx_o), .rx_fifo_write_o(rx_fifo_write_o),
      .rx_done_o(rx_done_o), .frame_error_o(frame_error_o), .parity_error_o(parity_error_o),
      .overrun_error_o(overrun_error_o), .busy_o(busy_o));

   always #5 clk = ~clk;

   initial forever begin
      @(negedge clk);
      tcnt = tcnt + 1;
      if (tcnt >= div) tcnt = 0;
      tick = (tcnt == 0);
   end

   always @(negedge clk) begin
      if (rx_done_o)
         q.push_back('{data_rx_o, frame_error_o, parity_error_o, rx_fifo_write_o, overrun_error_o});
      if ((rx_fifo_write_o || overrun_error_o) && !rx_done_o) stray++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic drive_bit(input logic b);
      rx = b;
      repeat (16*div) @(negedge clk);
   endtask

   task automatic wait_rec(output bit ok);
      ok = 0;
      for (int i = 0; i < 64*div; i++) begin
         if (q.size() > 0) begin ok = 1; break; end
         @(negedge clk);
      end
   endtask

   // Reference: data masked to N bits, parity/frame errors from what was put on the line,
   // FIFO write unless full, overrun when full.
   task automatic run_frame(input logic [1:0] fdw, input bit fpen, input bit fodd, input bit fs2,
                            input logic [7:0] d, input bit bpar, input bit bstop,
                            input bit ffull, input string tag);
      int         n;
      logic [7:0] mask, m;
      bit         p, ok;
      rec_t       r;
      n    = 5 + int'(fdw);
      mask = 8'hFF >> (8 - n);
      m    = d & mask;
      p    = (^m) ^ fodd ^ bpar;
      chk({tag, ":pre_empty"}, q.size(), 0);
      dw = fdw; pen = fpen; podd = fodd; s2 = fs2; full = ffull;
      @(negedge clk);
      drive_bit(1'b0);
      {dw, pen, podd, s2} = 5'($urandom);
      for (int i = 0; i < n; i++) drive_bit(m[i]);
      if (fpen) drive_bit(p);
      drive_bit(!bstop);
      if (fs2) drive_bit(1'b1);
      rx = 1'b1;
      wait_rec(ok);
      chk({tag, ":done"}, ok, 1);
      if (ok) begin
         r = q.pop_front();
         chk({tag, ":data"}, r.d, m);
         chk({tag, ":ferr"}, r.fe, bstop);
         chk({tag, ":perr"}, r.pe, fpen & bpar);
         chk({tag, ":write"}, r.wr, !ffull);
         chk({tag, ":ovr"}, r.ov, ffull);
      end
      repeat (4) @(negedge clk);
      chk({tag, ":idle"}, busy_o, 0);
      chk({tag, ":ferr_hold"}, frame_error_o, bstop);
      full = 1'b0;
      repeat (16*div) @(negedge clk);
   endtask

   initial begin
      bit ok;
      repeat (3) @(negedge clk);
      chk("reset_outs", {data_rx_o, busy_o, rx_done_o, rx_fifo_write_o,
                         frame_error_o, parity_error_o, overrun_error_o}, 0);
      rst = 1'b0;
      repeat (40) @(negedge clk);

      run_frame(2'd3, 0, 0, 0, 8'hA5, 0, 0, 0, "t1_8n1");
      run_frame(2'd2, 1, 0, 0, 8'h35, 1, 0, 0, "t2_7e1_badpar");
      run_frame(2'd3, 0, 0, 0, 8'h5A, 0, 1, 0, "t3_badstop");
      run_frame(2'd3, 0, 0, 0, 8'h11, 0, 0, 0, "t3_recover");
      chk("t3_perr_clear", parity_error_o, 0);

      // short low glitch: false start, no frame
      rx = 1'b0;
      repeat (4*div) @(negedge clk);
      rx = 1'b1;
      repeat (2*div) @(negedge clk);
      chk("t4_in_start", busy_o, 1);
      repeat (48*div) @(negedge clk);
      chk("t4_no_frame", q.size(), 0);
      chk("t4_idle", busy_o, 0);

      run_frame(2'd0, 1, 1, 1, 8'h1F, 0, 0, 1, "t5_5o2_full");

      // reset during data bit 3
      dw = 2'd3; pen = 0; s2 = 0;
      @(negedge clk);
      drive_bit(1'b0);
      drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b0);
      rx = 1'b1;
      repeat (8*div) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("t6_rst_outs", {data_rx_o, busy_o, rx_done_o, rx_fifo_write_o,
                          frame_error_o, parity_error_o, overrun_error_o}, 0);
      rst = 1'b0;
      repeat (48*div) @(negedge clk);
      chk("t6_no_frame", q.size(), 0);
      run_frame(2'd3, 0, 0, 0, 8'h3C, 0, 0, 0, "t6_after");

      // receiver disabled: frame ignored entirely
      en = 1'b0;
      dw = 2'd3; pen = 0; s2 = 0;
      @(negedge clk);
      drive_bit(1'b0);
      chk("dis_busy", busy_o, 0);
      for (int i = 0; i < 8; i++) drive_bit(1'b0);
      drive_bit(1'b1);
      repeat (32*div) @(negedge clk);
      chk("dis_no_frame", q.size(), 0);
      en = 1'b1;

      // break: one frame with framing error and zero data, no re-arm while low
      dw = 2'd3; pen = 0; s2 = 0;
      @(negedge clk);
      rx = 1'b0;
      repeat (16*div*14) @(negedge clk);
      chk("brk_one_frame", q.size(), 1);
      chk("brk_idle_low", busy_o, 0);
      rx = 1'b1;
      repeat (32*div) @(negedge clk);
      wait_rec(ok);
      chk("brk_done", ok, 1);
      if (ok) begin
         rec_t r;
         r = q.pop_front();
         chk("brk_data", r.d, 0);
         chk("brk_ferr", r.fe, 1);
         chk("brk_write", r.wr, 1);
      end
      chk("brk_no_extra", q.size(), 0);

      // randomized frames
      for (int k = 0; k < 14; k++) begin
         logic [1:0] rdw;
         bit rpen, rodd, rs2, rbp, rbs, rfull;
         div   = int'($urandom_range(2, 4));
         rdw   = 2'($urandom);
         rpen  = 1'($urandom);
         rodd  = 1'($urandom);
         rs2   = 1'($urandom);
         rbp   = ($urandom_range(0, 3) == 0);
         rbs   = ($urandom_range(0, 4) == 0);
         rfull = ($urandom_range(0, 4) == 0);
         run_frame(rdw, rpen, rodd, rs2, 8'($urandom), rbp, rbs, rfull, $sformatf("rnd%0d", k));
      end

      chk("stray_strobes", stray, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
